// File: rtl/modexp_pkg.sv
// Shared definitions for the modular exponentiation core: FSM encoding and
// the fixed cycle cost of one modular multiply.
package modexp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REDUCE,
        MUL,
        SQR,
        DONE
    } state_t;

    // One issue cycle, one iteration per operand bit, one writeback cycle.
    function automatic int unsigned mul_latency(input int unsigned width);
        return width + 32'd2;
    endfunction

endpackage

// File: rtl/modexp_core_mod_mul.sv
// Interleaved shift-add modular multiplier: p = (a * b) mod m, scanning b MSB-first.
// Requires a_in < m_in and m_in >= 2; b_in may be any value.
module mod_mul
    import modexp_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH-1:0] p_out,
    output logic             done_out
);

    localparam int unsigned ITERS = mul_latency(WIDTH) - 2;
    localparam int unsigned CW    = $clog2(ITERS + 1);

    logic [WIDTH+1:0] acc;
    logic [WIDTH+1:0] a_r;
    logic [WIDTH+1:0] m_r;
    logic [WIDTH-1:0] b_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] m2;
    logic [WIDTH+1:0] nxt;

    // acc < m and a < m keep 2*acc + a below 3m, so at most two subtractions.
    always_comb begin
        sum = (acc << 1) + (b_r[WIDTH-1] ? a_r : '0);
        m2  = m_r << 1;
        if (sum >= m2) begin
            nxt = sum - m2;
        end else if (sum >= m_r) begin
            nxt = sum - m_r;
        end else begin
            nxt = sum;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc      <= '0;
            a_r      <= '0;
            m_r      <= '0;
            b_r      <= '0;
            cnt      <= '0;
            p_out    <= '0;
            done_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            if (start_in) begin
                acc <= '0;
                a_r <= {2'b00, a_in};
                m_r <= {2'b00, m_in};
                b_r <= b_in;
                cnt <= CW'(ITERS);
            end else if (cnt != '0) begin
                acc <= nxt;
                b_r <= b_r << 1;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    p_out    <= nxt[WIDTH-1:0];
                    done_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/modexp_core.sv
// Right-to-left binary modular exponentiation built around one shared
// mod_mul; handles m=0, m=1 and e=0 without touching the multiplier.
module modexp_core
    import modexp_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned EXP_WIDTH = WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 ready_in,
    input  logic                 abort_in,
    input  logic [WIDTH-1:0]     value_in,
    input  logic [WIDTH-1:0]     modulus_in,
    input  logic [EXP_WIDTH-1:0] exponent_in,
    output logic [WIDTH-1:0]     value_out,
    output logic                 busy_out,
    output logic                 valid_out,
    output logic                 error_out
);

    state_t               state;
    logic [WIDTH-1:0]     base_r;
    logic [WIDTH-1:0]     mod_r;
    logic [WIDTH-1:0]     res_r;
    logic [EXP_WIDTH-1:0] exp_r;
    logic                 err_r;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 issue_r;
    logic [WIDTH-1:0]     mm_p;
    logic                 mm_done;
    logic                 op_done;

    mod_mul #(.WIDTH(WIDTH)) u_mod_mul (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .start_in (issue_r),
        .a_in     (op_a),
        .b_in     (op_b),
        .m_in     (mod_r),
        .p_out    (mm_p),
        .done_out (mm_done)
    );

    // A stale done from an aborted multiply can only coincide with the issue cycle.
    assign op_done = mm_done && !issue_r;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            base_r    <= '0;
            mod_r     <= '0;
            res_r     <= '0;
            exp_r     <= '0;
            err_r     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            issue_r   <= 1'b0;
            value_out <= '0;
            busy_out  <= 1'b0;
            valid_out <= 1'b0;
            error_out <= 1'b0;
        end else begin
            issue_r   <= 1'b0;
            valid_out <= 1'b0;
            if (abort_in) begin
                state    <= IDLE;
                busy_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        busy_out <= 1'b0;
                        if (ready_in && !busy_out) begin
                            base_r   <= value_in;
                            mod_r    <= modulus_in;
                            exp_r    <= exponent_in;
                            busy_out <= 1'b1;
                            state    <= CHECK;
                        end
                    end
                    CHECK: begin
                        res_r <= WIDTH'(1);
                        err_r <= 1'b0;
                        if (mod_r == '0) begin
                            res_r <= '0;
                            err_r <= 1'b1;
                            state <= DONE;
                        end else if (mod_r == WIDTH'(1)) begin
                            res_r <= '0;
                            state <= DONE;
                        end else if (exp_r == '0) begin
                            state <= DONE;
                        end else begin
                            op_a    <= WIDTH'(1);
                            op_b    <= base_r;
                            issue_r <= 1'b1;
                            state   <= REDUCE;
                        end
                    end
                    REDUCE: begin
                        if (op_done) begin
                            base_r  <= mm_p;
                            issue_r <= 1'b1;
                            if (exp_r[0]) begin
                                op_a  <= res_r;
                                op_b  <= mm_p;
                                state <= MUL;
                            end else begin
                                op_a  <= mm_p;
                                op_b  <= mm_p;
                                state <= SQR;
                            end
                        end
                    end
                    MUL: begin
                        if (op_done) begin
                            res_r <= mm_p;
                            if ((exp_r >> 1) == '0) begin
                                state <= DONE;
                            end else begin
                                op_a    <= base_r;
                                op_b    <= base_r;
                                issue_r <= 1'b1;
                                state   <= SQR;
                            end
                        end
                    end
                    SQR: begin
                        if (op_done) begin
                            base_r  <= mm_p;
                            exp_r   <= exp_r >> 1;
                            issue_r <= 1'b1;
                            if (exp_r[1]) begin
                                op_a  <= res_r;
                                op_b  <= mm_p;
                                state <= MUL;
                            end else begin
                                op_a  <= mm_p;
                                op_b  <= mm_p;
                                state <= SQR;
                            end
                        end
                    end
                    DONE: begin
                        value_out <= res_r;
                        error_out <= err_r;
                        valid_out <= 1'b1;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_modexp_core.sv
// Directed and random checks of modexp_core against a software model,
// with a scoreboard of expected results and latencies.
module tb_modexp_core;
    import modexp_pkg::*;

    localparam int unsigned W = 16;

    logic         clk_in      = 1'b0;
    logic         rst_in      = 1'b0;
    logic         ready_in    = 1'b0;
    logic         abort_in    = 1'b0;
    logic [W-1:0] value_in    = '0;
    logic [W-1:0] modulus_in  = '0;
    logic [W-1:0] exponent_in = '0;
    logic [W-1:0] value_out;
    logic         busy_out;
    logic         valid_out;
    logic         error_out;

    modexp_core #(.WIDTH(W), .EXP_WIDTH(W)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .ready_in    (ready_in),
        .abort_in    (abort_in),
        .value_in    (value_in),
        .modulus_in  (modulus_in),
        .exponent_in (exponent_in),
        .value_out   (value_out),
        .busy_out    (busy_out),
        .valid_out   (valid_out),
        .error_out   (error_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [W-1:0] val;
        logic         err;
        int           lat;
        int           t_acc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_x;
    int           n_cmp    = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    logic [W-1:0] last_val = '0;
    logic         last_err = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic void model(input logic [W-1:0] v, input logic [W-1:0] m,
                                  input logic [W-1:0] e, output logic [W-1:0] r,
                                  output logic err, output int lat);
        longint unsigned b;
        longint unsigned acc;
        int pop = 0;
        int n   = 0;
        err = (m == '0);
        lat = 2;
        r   = '0;
        if (m == '0 || m == W'(1)) begin
            r = '0;
        end else if (e == '0) begin
            r = W'(1);
        end else begin
            b   = longint'(v) % longint'(m);
            acc = 1;
            for (int i = 0; i < int'(W); i++) begin
                if (e[i]) begin
                    acc = (acc * b) % longint'(m);
                    pop++;
                    n = i + 1;
                end
                b = (b * b) % longint'(m);
            end
            r   = acc[W-1:0];
            lat = 2 + int'(mul_latency(W)) * (pop + n);
        end
    endfunction

    // Called at a falling edge; the request is sampled on the next rising edge.
    task automatic start_op(input logic [W-1:0] v, input logic [W-1:0] m,
                            input logic [W-1:0] e, input bit expect_result);
        exp_t x;
        value_in    = v;
        modulus_in  = m;
        exponent_in = e;
        ready_in    = 1'b1;
        if (expect_result) begin
            model(v, m, e, x.val, x.err, x.lat);
            x.t_acc = cyc + 1;
            sb.push_back(x);
        end
        @(negedge clk_in);
        ready_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int  k = 0;
        bit  ok;
        while ((sb.size() != 0 || busy_out) && k < budget) begin
            @(negedge clk_in);
            k++;
        end
        ok = (sb.size() == 0) && !busy_out;
        check(tag, 32'(ok), 32'd1);
        if (!ok) sb.delete();
    endtask

    always @(negedge clk_in) begin
        if (valid_out) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(valid_out), 32'd0);
            end else begin
                mon_x = sb.pop_front();
                check("value_out", 32'(value_out), 32'(mon_x.val));
                check("error_out", 32'(error_out), 32'(mon_x.err));
                check("latency", 32'(cyc - mon_x.t_acc), 32'(mon_x.lat));
                last_val = mon_x.val;
                last_err = mon_x.err;
            end
        end
    end

    initial begin
        logic [W-1:0] rv;
        logic [W-1:0] rm;
        logic [W-1:0] re;

        #2 rst_in = 1'b1;
        #2;
        check("rst_value", 32'(value_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_error", 32'(error_out), 32'd0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;

        // First accept on the first rising edge after reset release.
        start_op(16'd3, 16'd7, 16'd5, 1'b1);
        wait_idle("idle_3_7_5", 300);
        start_op(16'd100, 16'd7, 16'd1, 1'b1);
        wait_idle("idle_100_7_1", 300);
        start_op(16'd65535, 16'd65521, 16'd65535, 1'b1);
        wait_idle("idle_big", 1000);

        start_op(16'd77, 16'd0, 16'd3, 1'b1);
        wait_idle("idle_m0", 50);
        start_op(16'd77, 16'd1, 16'd9, 1'b1);
        wait_idle("idle_m1", 50);
        start_op(16'd77, 16'd13, 16'd0, 1'b1);
        wait_idle("idle_e0", 50);

        // Abort part-way through a run; outputs hold and no result appears.
        start_op(16'd3, 16'd7, 16'd5, 1'b0);
        repeat (19) @(negedge clk_in);
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        check("abort_busy", 32'(busy_out), 32'd0);
        check("abort_value_hold", 32'(value_out), 32'(last_val));
        check("abort_error_hold", 32'(error_out), 32'(last_err));
        repeat (100) @(negedge clk_in);
        start_op(16'd2, 16'd1000, 16'd10, 1'b1);
        wait_idle("idle_2_1000_10", 500);

        // New inputs and a second request while busy must not disturb the run.
        start_op(16'd3, 16'd7, 16'd5, 1'b1);
        repeat (10) @(negedge clk_in);
        value_in    = 16'd9;
        modulus_in  = 16'd11;
        exponent_in = 16'd3;
        ready_in    = 1'b1;
        @(negedge clk_in);
        ready_in = 1'b0;
        wait_idle("idle_ignore", 300);

        // Abort and request together in IDLE: the request is dropped.
        value_in   = 16'd5;
        modulus_in = 16'd0;
        ready_in   = 1'b1;
        abort_in   = 1'b1;
        @(negedge clk_in);
        ready_in = 1'b0;
        abort_in = 1'b0;
        check("abort_ready_busy", 32'(busy_out), 32'd0);
        repeat (10) @(negedge clk_in);

        // Asynchronous reset mid-run, away from a clock edge.
        start_op(16'd12345, 16'd40000, 16'd300, 1'b0);
        repeat (30) @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        check("midrst_value", 32'(value_out), 32'd0);
        check("midrst_busy", 32'(busy_out), 32'd0);
        check("midrst_valid", 32'(valid_out), 32'd0);
        check("midrst_error", 32'(error_out), 32'd0);
        @(negedge clk_in);
        rst_in   = 1'b0;
        last_val = '0;
        last_err = 1'b0;
        repeat (600) @(negedge clk_in);

        for (int i = 0; i < 200; i++) begin
            rv = W'($urandom);
            rm = W'($urandom);
            re = W'($urandom_range(0, 255));
            if (i % 25 == 0) rm = W'(i % 2);
            if (i % 16 == 3) rm = W'($urandom_range(2, 9));
            if (i % 10 == 7) re = W'($urandom);
            start_op(rv, rm, re, 1'b1);
            wait_idle("idle_rand", 2000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
